hps_ext_cdio: RTL and testbench

HPS_EXT_CDIO -- requirements
Module: hps_ext_cdio

---
 rtl/hps_ext_pkg.sv | 38 +++
 rtl/hps_ext_wordbuf.sv | 56 +++++
 rtl/hps_ext_cdio.sv | 171 +++++++++++++++++
 tb/tb_hps_ext_cdio.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_ext_pkg.sv
// Shared constants for the HPS extension command/data channel: command word
// defaults, EXT_BUS bit positions and a small command decoder.
package hps_ext_pkg;

  localparam logic [15:0] CMD_GET_DEFAULT = 16'h0034;
  localparam logic [15:0] CMD_SET_DEFAULT = 16'h0035;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 9;

  localparam int BUS_WIDTH    = 36;
  localparam int BUS_DOUT_LSB = 0;
  localparam int BUS_DIN_LSB  = 16;
  localparam int BUS_DOUT_EN  = 32;
  localparam int BUS_STROBE   = 33;
  localparam int BUS_ENABLE   = 34;
  localparam int BUS_SPARE    = 35;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_GET,
    KIND_SET
  } cmd_kind_e;

  function automatic cmd_kind_e decode_cmd(input logic [15:0] word,
                                           input logic [15:0] get_cmd,
                                           input logic [15:0] set_cmd);
    cmd_kind_e kind;
    kind = KIND_NONE;
    if (word == get_cmd) begin
      kind = KIND_GET;
    end else if (word == set_cmd) begin
      kind = KIND_SET;
    end
    return kind;
  endfunction

endpackage

// File: rtl/hps_ext_wordbuf.sv
// Array of 16-bit words with a whole-array snapshot load, an indexed single
// word write and an indexed combinational read (zero when out of range).
module hps_ext_wordbuf
  import hps_ext_pkg::*;
#(
  parameter int WORDS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [16*WORDS-1:0]     load_data,
  input  logic                    wr_en,
  input  logic [7:0]              wr_idx,
  input  logic [WORD_W-1:0]       wr_data,
  input  logic [7:0]              rd_idx,
  output logic [WORD_W-1:0]       rd_data,
  output logic [16*WORDS-1:0]     all_data
);

  logic [WORD_W-1:0] mem_q [WORDS];
  logic [WORD_W-1:0] mem_d [WORDS];

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      // Snapshot load wins over an indexed write in the same cycle.
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (load) begin
          mem_d[gi] = load_data[16*gi +: 16];
        end else if (wr_en && (wr_idx == 8'(gi))) begin
          mem_d[gi] = wr_data;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end

      assign all_data[16*gi +: 16] = mem_q[gi];
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (rd_idx == 8'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/hps_ext_cdio.sv
// HPS extension command/data port: a command strobe selects a snapshot read of
// core status words (GET) or a staged, all-or-nothing write of a payload (SET).
module hps_ext_cdio
  import hps_ext_pkg::*;
#(
  parameter logic [15:0] CMD_GET   = CMD_GET_DEFAULT,
  parameter logic [15:0] CMD_SET   = CMD_SET_DEFAULT,
  parameter int          GET_WORDS = 8,
  parameter int          SET_WORDS = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  inout  wire  [BUS_WIDTH-1:0]     EXT_BUS,
  input  logic [16*GET_WORDS-1:0]  get_data,
  output logic [16*SET_WORDS-1:0]  set_data,
  output logic                     set_valid,
  output logic                     get_done,
  output logic                     heartbeat
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] GET_LIMIT = CNT_W'(GET_WORDS);
  localparam logic [CNT_W-1:0] SET_LIMIT = CNT_W'(SET_WORDS);

  logic [WORD_W-1:0] io_din;
  logic              io_strobe;
  logic              io_enable;

  assign io_din    = EXT_BUS[BUS_DIN_LSB +: WORD_W];
  assign io_strobe = EXT_BUS[BUS_STROBE];
  assign io_enable = EXT_BUS[BUS_ENABLE];

  logic unused_spare;
  assign unused_spare = EXT_BUS[BUS_SPARE];

  logic [WORD_W-1:0]      io_dout_q, io_dout_d;
  logic                   dout_en_q, dout_en_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]      cmd_q, cmd_d;
  logic                   armed_q, armed_d;
  logic                   was_active_q, was_active_d;
  logic [16*SET_WORDS-1:0] set_data_q, set_data_d;
  logic                   set_valid_q, set_valid_d;
  logic                   get_done_q, get_done_d;
  logic                   heartbeat_q, heartbeat_d;

  logic                   shadow_load;
  logic [WORD_W-1:0]      shadow_rd;
  logic                   stage_wr;
  logic [7:0]             stage_idx;
  logic [16*SET_WORDS-1:0] stage_all;
  logic [16*GET_WORDS-1:0] unused_shadow_all;
  logic [WORD_W-1:0]      unused_stage_rd;

  logic      active;
  cmd_kind_e cur_kind;
  cmd_kind_e new_kind;

  // Only an enable period that started after reset (armed) may run a transaction.
  assign active   = io_enable && armed_q;
  assign cur_kind = decode_cmd(cmd_q, CMD_GET, CMD_SET);
  assign new_kind = decode_cmd(io_din, CMD_GET, CMD_SET);

  always_comb begin
    io_dout_d    = io_dout_q;
    dout_en_d    = dout_en_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    armed_d      = armed_q;
    was_active_d = active;
    set_data_d   = set_data_q;
    set_valid_d  = 1'b0;
    get_done_d   = 1'b0;
    heartbeat_d  = heartbeat_q;
    shadow_load  = 1'b0;
    stage_wr     = 1'b0;
    stage_idx    = 8'(cnt_q - 9'd1);

    if (!io_enable) begin
      io_dout_d = '0;
      dout_en_d = 1'b0;
      cnt_d     = '0;
      cmd_d     = '0;
      armed_d   = 1'b1;
      // Close only a transaction that actually received a command strobe.
      if (was_active_q && (cnt_q != '0)) begin
        if (cur_kind == KIND_GET) begin
          get_done_d  = 1'b1;
          heartbeat_d = ~heartbeat_q;
        end else if ((cur_kind == KIND_SET) && (cnt_q == SET_LIMIT + 9'd1)) begin
          set_valid_d = 1'b1;
          set_data_d  = stage_all;
        end
      end
    end else if (active && io_strobe) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 9'd1;
      if (cnt_q == '0) begin
        cmd_d       = io_din;
        dout_en_d   = (new_kind != KIND_NONE);
        shadow_load = (new_kind == KIND_GET);
        // Shadow word 0 equals get_data word 0 on the snapshot cycle.
        io_dout_d   = (new_kind == KIND_GET) ? get_data[WORD_W-1:0] : '0;
      end else if (cur_kind == KIND_GET) begin
        io_dout_d = (cnt_q < GET_LIMIT) ? shadow_rd : '0;
      end else if ((cur_kind == KIND_SET) && (cnt_q <= SET_LIMIT)) begin
        stage_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      io_dout_q    <= '0;
      dout_en_q    <= 1'b0;
      cnt_q        <= '0;
      cmd_q        <= '0;
      armed_q      <= 1'b0;
      was_active_q <= 1'b0;
      set_data_q   <= '0;
      set_valid_q  <= 1'b0;
      get_done_q   <= 1'b0;
      heartbeat_q  <= 1'b0;
    end else begin
      io_dout_q    <= io_dout_d;
      dout_en_q    <= dout_en_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      armed_q      <= armed_d;
      was_active_q <= was_active_d;
      set_data_q   <= set_data_d;
      set_valid_q  <= set_valid_d;
      get_done_q   <= get_done_d;
      heartbeat_q  <= heartbeat_d;
    end
  end

  hps_ext_wordbuf #(.WORDS(GET_WORDS)) u_shadow (
    .clk       (clk_sys),
    .rst       (reset),
    .load      (shadow_load),
    .load_data (get_data),
    .wr_en     (1'b0),
    .wr_idx    (8'd0),
    .wr_data   (16'd0),
    .rd_idx    (cnt_q[7:0]),
    .rd_data   (shadow_rd),
    .all_data  (unused_shadow_all)
  );

  hps_ext_wordbuf #(.WORDS(SET_WORDS)) u_staging (
    .clk       (clk_sys),
    .rst       (reset),
    .load      (1'b0),
    .load_data ('0),
    .wr_en     (stage_wr),
    .wr_idx    (stage_idx),
    .wr_data   (io_din),
    .rd_idx    (8'd0),
    .rd_data   (unused_stage_rd),
    .all_data  (stage_all)
  );

  assign EXT_BUS[BUS_DOUT_LSB +: WORD_W] = io_dout_q;
  assign EXT_BUS[BUS_DOUT_EN]            = dout_en_q;

  assign set_data  = set_data_q;
  assign set_valid = set_valid_q;
  assign get_done  = get_done_q;
  assign heartbeat = heartbeat_q;

endmodule

// File: tb/tb_hps_ext_cdio.sv
// Scoreboard bench for hps_ext_cdio: stimulus queues expected outputs, a
// negedge monitor pops and compares on every sampled strobe/probe and pulse.
module tb_hps_ext_cdio;

  logic         clk = 1'b0;
  logic         tb_reset = 1'b1;
  logic [15:0]  tb_din = '0;
  logic         tb_strobe = 1'b0;
  logic         tb_enable = 1'b0;
  logic         tb_probe = 1'b0;
  logic [127:0] tb_get = '0;
  logic         stim_done = 1'b0;
  logic         samp_q = 1'b0;

  wire  [35:0]  ext_bus;
  wire  [127:0] set_data;
  wire          set_valid;
  wire          get_done;
  wire          heartbeat;

  assign ext_bus[31:16] = tb_din;
  assign ext_bus[33]    = tb_strobe;
  assign ext_bus[34]    = tb_enable;
  assign ext_bus[35]    = 1'b0;

  hps_ext_cdio dut (
    .clk_sys   (clk),
    .reset     (tb_reset),
    .EXT_BUS   (ext_bus),
    .get_data  (tb_get),
    .set_data  (set_data),
    .set_valid (set_valid),
    .get_done  (get_done),
    .heartbeat (heartbeat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         en;
    logic [15:0]  dout;
    logic         hb;
    logic [127:0] sd;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] set_q[$];
  logic         get_q[$];

  logic [127:0] cur_set = '0;
  logic         cur_hb = 1'b0;

  always @(posedge clk) samp_q <= tb_strobe | tb_probe;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic en, input logic [15:0] dout);
    exp_t e;
    e.en = en; e.dout = dout; e.hb = cur_hb; e.sd = cur_set;
    exp_q.push_back(e);
  endtask

  task automatic strobe_word(input logic [15:0] w, input logic en, input logic [15:0] dout);
    tb_din = w;
    tb_strobe = 1'b1;
    push_exp(en, dout);
    tick();
    tb_strobe = 1'b0;
    tick();
  endtask

  task automatic probe(input logic en, input logic [15:0] dout);
    tb_probe = 1'b1;
    push_exp(en, dout);
    tick();
    tb_probe = 1'b0;
    tick();
  endtask

  task automatic open_txn();
    tb_enable = 1'b1;
    tick();
  endtask

  task automatic close_txn();
    tb_enable = 1'b0;
    repeat (3) tick();
  endtask

  function automatic logic [127:0] make_words(input logic [15:0] base);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[16*i +: 16] = base + 16'(i);
    return v;
  endfunction

  task automatic full_set(input logic [15:0] base);
    logic [127:0] w;
    w = make_words(base);
    open_txn();
    strobe_word(16'h0035, 1'b1, 16'h0000);
    for (int i = 0; i < 8; i++) strobe_word(w[16*i +: 16], 1'b1, 16'h0000);
    set_q.push_back(w);
    cur_set = w;
    close_txn();
    probe(1'b0, 16'h0000);
  endtask

  // Stimulus
  initial begin
    repeat (3) tick();
    probe(1'b0, 16'h0000);
    tb_reset = 1'b0;
    repeat (2) tick();

    // GET: 9 strobes read 0x1000..0x1007 then 0
    tb_get = make_words(16'h1000);
    open_txn();
    strobe_word(16'h0034, 1'b1, 16'h1000);
    for (int k = 1; k < 8; k++) strobe_word(16'h0000, 1'b1, 16'h1000 + 16'(k));
    strobe_word(16'h0000, 1'b1, 16'h0000);
    cur_hb = 1'b1;
    get_q.push_back(1'b1);
    close_txn();
    probe(1'b0, 16'h0000);

    // SET: full 8-word payload commits
    full_set(16'hA000);

    // SET: short payload of 5 words, no commit
    open_txn();
    strobe_word(16'h0035, 1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) strobe_word(16'h5000 + 16'(i), 1'b1, 16'h0000);
    close_txn();
    probe(1'b0, 16'h0000);

    // Unknown command 0x0036 with 3 words
    open_txn();
    strobe_word(16'h0036, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) strobe_word(16'h6000 + 16'(i), 1'b0, 16'h0000);
    close_txn();
    probe(1'b0, 16'h0000);

    // GET snapshot: get_data changes after the command strobe
    tb_get = make_words(16'h2000);
    open_txn();
    strobe_word(16'h0034, 1'b1, 16'h2000);
    tb_get = make_words(16'h3000);
    for (int k = 1; k < 4; k++) strobe_word(16'h0000, 1'b1, 16'h2000 + 16'(k));
    cur_hb = 1'b0;
    get_q.push_back(1'b0);
    close_txn();

    // Reset after word 4 of a SET aborts it; enable still high stays idle
    open_txn();
    strobe_word(16'h0035, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) strobe_word(16'hC000 + 16'(i), 1'b1, 16'h0000);
    tb_reset = 1'b1;
    cur_set = '0;
    cur_hb = 1'b0;
    probe(1'b0, 16'h0000);
    tb_reset = 1'b0;
    tick();
    strobe_word(16'h0035, 1'b0, 16'h0000);
    strobe_word(16'hDEAD, 1'b0, 16'h0000);
    close_txn();
    probe(1'b0, 16'h0000);

    // Next full SET after the abort commits normally
    full_set(16'hB000);

    repeat (4) tick();
    stim_done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    int   tests_run;
    int   fails;
    int   cycles;
    exp_t e;
    logic [127:0] sd_exp;
    logic hb_exp;
    tests_run = 0;
    fails = 0;
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (samp_q) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sample_queue: got a sample with no expectation queued, required a queued entry");
        end else begin
          e = exp_q.pop_front();
          if ({dout_en_w(), ext_bus[15:0], heartbeat, set_data} !== e) begin
            fails++;
            $display("FAIL outputs: got en=%b dout=%h hb=%b set=%h, required en=%b dout=%h hb=%b set=%h",
                     ext_bus[32], ext_bus[15:0], heartbeat, set_data, e.en, e.dout, e.hb, e.sd);
          end else begin
            $display("[TB] sample en=%b dout=%h hb=%b ok", e.en, e.dout, e.hb);
          end
        end
      end
      if (set_valid !== 1'b0) begin
        tests_run++;
        if (set_q.size() == 0) begin
          fails++;
          $display("FAIL set_valid_pulse: got set_valid=%b, required 0 (no commit expected)", set_valid);
        end else begin
          sd_exp = set_q.pop_front();
          if (set_data !== sd_exp) begin
            fails++;
            $display("FAIL set_commit: got set_data=%h, required %h", set_data, sd_exp);
          end else begin
            $display("[TB] commit set_data=%h ok", set_data);
          end
        end
      end
      if (get_done !== 1'b0) begin
        tests_run++;
        if (get_q.size() == 0) begin
          fails++;
          $display("FAIL get_done_pulse: got get_done=%b, required 0 (no close expected)", get_done);
        end else begin
          hb_exp = get_q.pop_front();
          if (heartbeat !== hb_exp) begin
            fails++;
            $display("FAIL heartbeat: got %b, required %b", heartbeat, hb_exp);
          end else begin
            $display("[TB] get_done heartbeat=%b ok", heartbeat);
          end
        end
      end
      if (stim_done || cycles > 20000) begin
        if (!stim_done) begin
          fails++;
          $display("FAIL timeout: got %0d cycles, required stimulus completion", cycles);
        end
        tests_run++;
        if (exp_q.size() != 0 || set_q.size() != 0 || get_q.size() != 0) begin
          fails++;
          $display("FAIL pending: got %0d samples, %0d commits, %0d closes outstanding, required 0",
                   exp_q.size(), set_q.size(), get_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
      end
    end
  end

  function automatic logic dout_en_w();
    return ext_bus[32];
  endfunction

endmodule
